// File: rtl/seg_display_ctrl_pkg.sv
// ============================================================================
// Module  : seg_display_ctrl_pkg
// Purpose : Register addresses, scan FSM encoding and nibble-select helper
//           shared by the 7-segment display controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_display_ctrl_pkg;

  // Register map
  localparam logic [1:0] ADDR_DATA0  = 2'd0;
  localparam logic [1:0] ADDR_DATA1  = 2'd1;
  localparam logic [1:0] ADDR_DPMASK = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  // Scan FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } scan_state_t;

  // Pick nibble idx out of the packed {d3,d2,d1,d0} digit word
  function automatic logic [3:0] nibble_sel(input logic [15:0] data, input logic [1:0] idx);
    return data[{idx, 2'b00} +: 4];
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg_display_ctrl_segled.sv
// ============================================================================
// Module  : seg_display_ctrl_segled
// Purpose : Hex nibble to 7-segment decoder, segs = {g,f,e,d,c,b,a},
//           active-high (1 = segment lit).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_display_ctrl_segled (
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  // Pure lookup of the standard hex glyphs
  always_comb begin
    segs = 7'b0000000;
    case (nibble)
      4'h0: segs = 7'b0111111;
      4'h1: segs = 7'b0000110;
      4'h2: segs = 7'b1011011;
      4'h3: segs = 7'b1001111;
      4'h4: segs = 7'b1100110;
      4'h5: segs = 7'b1101101;
      4'h6: segs = 7'b1111101;
      4'h7: segs = 7'b0000111;
      4'h8: segs = 7'b1111111;
      4'h9: segs = 7'b1101111;
      4'hA: segs = 7'b1110111;
      4'hB: segs = 7'b1111100;
      4'hC: segs = 7'b0111001;
      4'hD: segs = 7'b1011110;
      4'hE: segs = 7'b1111001;
      4'hF: segs = 7'b1110001;
      default: segs = 7'b0000000;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg_display_ctrl.sv
// ============================================================================
// Module  : seg_display_ctrl
// Purpose : Bus-mapped controller that time-multiplexes DIGITS hex digits
//           onto a shared 7-segment bus with an all-off dead band per slot.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_display_ctrl
  import seg_display_ctrl_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int DIV_W   = 16,
  parameter int DIV     = 50000,
  parameter int BLANK   = 64,
  parameter int SEG_INV = 0,
  parameter int DIG_INV = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              we,
  input  logic [1:0]        addr,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  output logic [6:0]        segs,
  output logic              dp,
  output logic [DIGITS-1:0] digit_en
);

  localparam logic [DIV_W-1:0] SHOW_LAST = DIV_W'(DIV - BLANK - 1);
  localparam logic [DIV_W-1:0] GAP_LAST  = DIV_W'(BLANK - 1);
  localparam logic [1:0]       IDX_LAST  = 2'(DIGITS - 1);

  logic [7:0] data0, data1;
  logic [3:0] dpmask, blank_mask;
  logic       en;

  scan_state_t      state, state_nx;
  logic [DIV_W-1:0] cnt, cnt_nx;
  logic [1:0]       idx, idx_nx, idx_inc;
  logic             enter_show;

  logic [3:0]        nibble;
  logic [6:0]        seg_dec;
  logic [6:0]        seg_q, seg_nx;
  logic              dp_q, dp_nx;
  logic [DIGITS-1:0] dig_q, dig_nx;

  // CPU register file; unused bits are never stored so they read back 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data0      <= 8'h00;
      data1      <= 8'h00;
      dpmask     <= 4'h0;
      blank_mask <= 4'h0;
      en         <= 1'b0;
    end else if (cs && we) begin
      case (addr)
        ADDR_DATA0:  data0  <= din;
        ADDR_DATA1:  data1  <= din;
        ADDR_DPMASK: dpmask <= din[3:0];
        ADDR_CTRL: begin
          blank_mask <= din[7:4];
          en         <= din[0];
        end
        default: ;
      endcase
    end
  end

  // Combinational read-back selected by addr
  always_comb begin
    dout = 8'h00;
    case (addr)
      ADDR_DATA0:  dout = data0;
      ADDR_DATA1:  dout = data1;
      ADDR_DPMASK: dout = {4'h0, dpmask};
      ADDR_CTRL:   dout = {blank_mask, 3'b000, en};
      default:     dout = 8'h00;
    endcase
  end

  // Scan state, slot counter and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= 2'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
    end
  end

  assign idx_inc = (idx == IDX_LAST) ? 2'd0 : idx + 2'd1;

  // Next-state: SHOW for DIV-BLANK cycles, then GAP for BLANK cycles
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt + DIV_W'(1);
    idx_nx     = idx;
    enter_show = 1'b0;
    if (!en) begin
      state_nx = ST_IDLE;
      cnt_nx   = '0;
      idx_nx   = 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nx   = ST_SHOW;
          cnt_nx     = '0;
          idx_nx     = 2'd0;
          enter_show = 1'b1;
        end
        ST_SHOW: begin
          if (cnt == SHOW_LAST) begin
            cnt_nx = '0;
            if (BLANK > 0) begin
              state_nx = ST_GAP;
            end else begin
              idx_nx     = idx_inc;
              enter_show = 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            state_nx   = ST_SHOW;
            cnt_nx     = '0;
            idx_nx     = idx_inc;
            enter_show = 1'b1;
          end
        end
        default: begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
          idx_nx   = 2'd0;
        end
      endcase
    end
  end

  assign nibble = nibble_sel({data1, data0}, idx_nx);

  seg_display_ctrl_segled u_segled (
    .nibble (nibble),
    .segs   (seg_dec)
  );

  // Output next-values: latch the entered digit, hold through SHOW, off otherwise
  always_comb begin
    seg_nx = seg_q;
    dp_nx  = dp_q;
    dig_nx = dig_q;
    if (state_nx != ST_SHOW) begin
      seg_nx = 7'b0000000;
      dp_nx  = 1'b0;
      dig_nx = '0;
    end else if (enter_show) begin
      seg_nx = seg_dec;
      dp_nx  = dpmask[idx_nx];
      dig_nx = blank_mask[idx_nx] ? '0 : (DIGITS'(1) << idx_nx);
    end
  end

  // Registered outputs so pins change only on slot boundaries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= 7'b0000000;
      dp_q  <= 1'b0;
      dig_q <= '0;
    end else begin
      seg_q <= seg_nx;
      dp_q  <= dp_nx;
      dig_q <= dig_nx;
    end
  end

  assign segs     = (SEG_INV != 0) ? ~seg_q : seg_q;
  assign dp       = (SEG_INV != 0) ? ~dp_q  : dp_q;
  assign digit_en = (DIG_INV != 0) ? ~dig_q : dig_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_display_ctrl.sv
// ============================================================================
// Module  : tb_seg_display_ctrl
// Purpose : Self-checking bench for seg_display_ctrl (DIV=8, with and
//           without dead band) against a time-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_display_ctrl;

  localparam int DIGITS = 4;
  localparam int DIV    = 8;
  localparam int BLANK  = 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       cs    = 1'b0;
  logic       we    = 1'b0;
  logic [1:0] addr  = 2'd0;
  logic [7:0] din   = 8'h00;

  logic [7:0] dout_a, dout_b;
  logic [6:0] segs_a, segs_b;
  logic       dp_a, dp_b;
  logic [3:0] den_a, den_b;

  seg_display_ctrl #(
    .DIGITS(DIGITS), .DIV_W(16), .DIV(DIV), .BLANK(BLANK), .SEG_INV(0), .DIG_INV(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .we(we), .addr(addr), .din(din),
    .dout(dout_a), .segs(segs_a), .dp(dp_a), .digit_en(den_a)
  );

  seg_display_ctrl #(
    .DIGITS(DIGITS), .DIV_W(16), .DIV(DIV), .BLANK(0), .SEG_INV(0), .DIG_INV(0)
  ) dut_nb (
    .clk(clk), .rst_n(rst_n), .cs(cs), .we(we), .addr(addr), .din(din),
    .dout(dout_b), .segs(segs_b), .dp(dp_b), .digit_en(den_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: registers plus elapsed cycles since scanning began (-1 = idle)
  logic [7:0] m_reg [4];
  int         t;
  logic [6:0] l_seg;
  logic       l_dp;
  logic [3:0] l_den;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0111111;  4'h1: return 7'b0000110;
      4'h2: return 7'b1011011;  4'h3: return 7'b1001111;
      4'h4: return 7'b1100110;  4'h5: return 7'b1101101;
      4'h6: return 7'b1111101;  4'h7: return 7'b0000111;
      4'h8: return 7'b1111111;  4'h9: return 7'b1101111;
      4'hA: return 7'b1110111;  4'hB: return 7'b1111100;
      4'hC: return 7'b0111001;  4'hD: return 7'b1011110;
      4'hE: return 7'b1111001;  default: return 7'b1110001;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
    t     = -1;
    l_seg = 7'b0;
    l_dp  = 1'b0;
    l_den = 4'b0;
  endtask

  // One clock edge: time advances with pre-edge registers, then the write lands
  task automatic model_edge();
    int         d;
    logic [7:0] bv;
    logic [3:0] nib;
    if (!m_reg[3][0]) begin
      t = -1;
    end else begin
      t++;
      if (t % DIV == 0) begin
        d     = (t / DIV) % DIGITS;
        bv    = (d < 2) ? m_reg[0] : m_reg[1];
        nib   = (d % 2 == 1) ? bv[7:4] : bv[3:0];
        l_seg = hex7(nib);
        l_dp  = m_reg[2][d];
        l_den = m_reg[3][4+d] ? 4'b0000 : 4'(1 << d);
      end
    end
    if (cs && we) begin
      case (addr)
        2'd2:    m_reg[2] = din & 8'h0F;
        2'd3:    m_reg[3] = din & 8'hF1;
        default: m_reg[addr] = din;
      endcase
    end
  endtask

  task automatic check_outputs();
    logic show_a, show_b;
    show_a = (t >= 0) && ((t % DIV) < DIV - BLANK);
    show_b = (t >= 0);
    check("segs_a", segs_a, show_a ? l_seg : 7'b0);
    check("dp_a",   dp_a,   show_a ? l_dp  : 1'b0);
    check("den_a",  den_a,  show_a ? l_den : 4'b0);
    check("segs_b", segs_b, show_b ? l_seg : 7'b0);
    check("dp_b",   dp_b,   show_b ? l_dp  : 1'b0);
    check("den_b",  den_b,  show_b ? l_den : 4'b0);
    check("dout_a", dout_a, m_reg[addr]);
    check("dout_b", dout_b, m_reg[addr]);
  endtask

  task automatic cycle(input logic c, input logic w, input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = c; we = w; addr = a; din = d;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'(i), 8'h00);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_segs", segs_a, 7'b0);
    check("rst_dp",   dp_a,   1'b0);
    check("rst_den",  den_a,  4'b0);
    check("rst_den_b", den_b, 4'b0);
    for (int i = 0; i < 4; i++) begin
      addr = 2'(i);
      #1;
      check("rst_dout", dout_a, 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #1;
    do_reset();

    // Directed frame: "4321" with EN
    cycle(1'b1, 1'b1, 2'd0, 8'h21);
    cycle(1'b1, 1'b1, 2'd1, 8'h43);
    cycle(1'b1, 1'b1, 2'd3, 8'h01);
    cycle(1'b0, 1'b0, 2'd0, 8'h00);
    check("dir_d0_en",   den_a,  4'b0001);
    check("dir_d0_segs", segs_a, 7'b0000110);
    idle_cycles(6);
    check("dir_gap_en",  den_a,  4'b0000);
    check("dir_nb_d0",   den_b,  4'b0001);
    idle_cycles(2);
    check("dir_d1_en",   den_a,  4'b0010);
    check("dir_d1_segs", segs_a, 7'b1011011);
    idle_cycles(16);
    check("dir_d3_segs", segs_a, 7'b1100110);
    idle_cycles(8);
    check("dir_wrap_en", den_a,  4'b0001);

    // Mid-slot write to DATA0 must not disturb the digit being shown
    cycle(1'b1, 1'b1, 2'd0, 8'h2F);
    check("dir_hold_segs", segs_a, 7'b0000110);
    idle_cycles(DIV * DIGITS);

    // DP mask and blank mask, then mid-scan disable and mid-scan reset
    cycle(1'b1, 1'b1, 2'd2, 8'h05);
    cycle(1'b1, 1'b1, 2'd3, 8'h21);
    idle_cycles(DIV * DIGITS * 2 + 19);
    cycle(1'b1, 1'b1, 2'd3, 8'h00);
    idle_cycles(3);
    cycle(1'b1, 1'b1, 2'd3, 8'h01);
    idle_cycles(DIV * 2 + 3);
    do_reset();
    idle_cycles(3);

    // Randomized register traffic with occasional disables and one async reset
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (i == 2000) begin
        do_reset();
      end else if (r < 8) begin
        cycle(1'b1, 1'b1, 2'($urandom_range(0, 2)), 8'($urandom));
      end else if (r < 11) begin
        cycle(1'b1, 1'b1, 2'd3, 8'($urandom) | 8'h01);
      end else if (r < 12) begin
        cycle(1'b1, 1'b1, 2'd3, 8'($urandom) & 8'hFE);
      end else if (r < 20) begin
        cycle(1'b1, 1'b0, 2'($urandom), 8'($urandom));
      end else if (r < 22 && m_reg[3][0] == 1'b0) begin
        cycle(1'b1, 1'b1, 2'd3, 8'h01);
      end else begin
        cycle(1'b0, 1'($urandom), 2'($urandom), 8'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
